// File: rtl/seg_dyn_disp.sv
// Six-digit multiplexed 7-segment driver with sequential binary-to-BCD conversion.
// Optional macro SEG_LZB_EN: enables leading-zero blanking and the minus sign.
//
// state | meaning
// IDLE  | wait for a new data value (or the first cycle after reset)
// LOAD  | capture saturated data, clear BCD work register
// SHIFT | 20 shift-add-3 iterations
// DONE  | copy work register into the display BCD register
module seg_dyn_disp #(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [19:0] data_sat;
  logic [19:0] last_data;
  logic [19:0] bin_sr;
  logic [23:0] bcd_work;
  logic [23:0] bcd_adj;
  logic [23:0] bcd_disp;
  logic [4:0]  shift_cnt;
  logic        first_conv;
  logic [15:0] scan_cnt;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic [7:0]  seg_nxt;

  assign data_sat = (data > 20'd999_999) ? 20'd999_999 : data;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (first_conv || (data != last_data)) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == 5'd19) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < 6; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
  end

  // Only the display register is visible, so it changes once per conversion.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_data  <= '0;
      bin_sr     <= '0;
      bcd_work   <= '0;
      bcd_disp   <= '0;
      shift_cnt  <= '0;
      first_conv <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          bin_sr     <= data_sat;
          last_data  <= data;
          bcd_work   <= '0;
          shift_cnt  <= '0;
          first_conv <= 1'b0;
        end
        SHIFT: begin
          bcd_work  <= {bcd_adj[22:0], bin_sr[19]};
          bin_sr    <= {bin_sr[18:0], 1'b0};
          shift_cnt <= shift_cnt + 5'd1;
        end
        DONE:    bcd_disp <= bcd_work;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 8'hC0;  4'd1: enc = 8'hF9;
      4'd2: enc = 8'hA4;  4'd3: enc = 8'hB0;
      4'd4: enc = 8'h99;  4'd5: enc = 8'h92;
      4'd6: enc = 8'h82;  4'd7: enc = 8'hF8;
      4'd8: enc = 8'h80;  4'd9: enc = 8'h90;
      default: enc = 8'hFF;
    endcase
  endfunction

  assign digit = bcd_disp[{idx, 2'b00} +: 4];

`ifdef SEG_LZB_EN
  logic [2:0] top;

  // Leftmost digit that must be lit: highest nonzero BCD digit or decimal point.
  always_comb begin
    top = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if ((bcd_disp[4*i +: 4] != 4'd0) || point[i]) top = 3'(i);
    end
  end

  always_comb begin
    seg_nxt = 8'hFF;
    if (idx <= top)                        seg_nxt = enc(digit) & {~point[idx], 7'h7F};
    else if (sign && (idx == top + 3'd1))  seg_nxt = 8'hBF;
  end
`else
  logic sign_unused;
  assign sign_unused = sign;

  always_comb begin
    seg_nxt = enc(digit) & {~point[idx], 7'h7F};
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= '0;
      seg <= 8'hFF;
    end else if (seg_en) begin
      sel <= 6'd1 << idx;
      seg <= seg_nxt;
    end else begin
      sel <= '0;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_dyn_disp.sv
// Directed testbench for seg_dyn_disp with a short scan slot (CNT_MAX=9).
// Expected digit patterns follow SEG_LZB_EN, so the bench works in either build.
module tb_seg_dyn_disp;
  localparam logic [15:0] CNT_MAX = 16'd9;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int total = 0;
  int bad   = 0;

  logic [5:0] fr_sel [60];
  logic [7:0] fr_seg [60];
  logic [7:0] exp_seg [6];

  seg_dyn_disp #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .sign(sign), .seg_en(seg_en), .sel(sel), .seg(seg)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Align to the start of digit 0 and record one full 60-cycle scan frame.
  task automatic capture_frame(output bit found);
    logic [5:0] prev;
    found = 1'b0;
    prev  = sel;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge sys_clk);
      if (sel == 6'b000001 && prev == 6'b100000) found = 1'b1;
      else prev = sel;
    end
    fr_sel[0] = sel;
    fr_seg[0] = seg;
    for (int k = 1; k < 60; k++) begin
      @(negedge sys_clk);
      fr_sel[k] = sel;
      fr_seg[k] = seg;
    end
  endtask

  task automatic test_reset;
    data = 20'd0; point = 6'd0; sign = 1'b0; seg_en = 1'b1;
    sys_rst_n = 1'b0;
    #12;
    total++; if (sel !== 6'b0)  begin bad++; $display("FAIL reset_sel: got %b want 000000", sel); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h want ff", seg); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(1);
    total++; if (sel !== 6'b000001) begin bad++; $display("FAIL reset_first_sel: got %b want 000001", sel); end
    total++; if (seg !== 8'hC0)     begin bad++; $display("FAIL reset_first_seg: got %h want c0", seg); end
  endtask

  task automatic check_frame_named(input string name);
    bit found;
    capture_frame(found);
    total++; if (found !== 1'b1) begin bad++; $display("FAIL %s_sync: got %0b want 1", name, found); end
    for (int k = 0; k < 60; k++) begin
      logic [5:0] es;
      es = 6'd1 << (k / 10);
      total++; if (fr_sel[k] !== es) begin bad++; $display("FAIL %s_sel[%0d]: got %b want %b", name, k, fr_sel[k], es); end
      total++; if (fr_seg[k] !== exp_seg[k/10]) begin bad++; $display("FAIL %s_seg[%0d]: got %h want %h", name, k, fr_seg[k], exp_seg[k/10]); end
    end
  endtask

  task automatic test_basic;
    data = 20'd123456; point = 6'd0; sign = 1'b0;
    tick(30);
    exp_seg = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    check_frame_named("basic");
  endtask

  task automatic test_sign;
    data = 20'd42; point = 6'd0; sign = 1'b1;
    tick(30);
`ifdef SEG_LZB_EN
    exp_seg = '{8'hA4, 8'h99, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
`else
    exp_seg = '{8'hA4, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    check_frame_named("sign");
  endtask

  task automatic test_point;
    data = 20'd5; point = 6'b000100; sign = 1'b0;
    tick(30);
`ifdef SEG_LZB_EN
    exp_seg = '{8'h92, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF};
`else
    exp_seg = '{8'h92, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0};
`endif
    check_frame_named("point");
    data = 20'd7; point = 6'b100000;
    tick(30);
    exp_seg = '{8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40};
    check_frame_named("point5");
  endtask

  task automatic test_zero_sign;
    data = 20'd0; point = 6'd0; sign = 1'b1;
    tick(30);
`ifdef SEG_LZB_EN
    exp_seg = '{8'hC0, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    exp_seg = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    check_frame_named("zero_sign");
  endtask

  task automatic test_saturate;
    data = 20'hFFFFF; point = 6'd0; sign = 1'b1;
    tick(30);
    exp_seg = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90};
    check_frame_named("saturate");
    sign = 1'b0;
  endtask

  task automatic test_latency;
    data = 20'd111111; point = 6'd0; sign = 1'b0;
    tick(30);
    data = 20'd333333;
    tick(20);
    total++; if (seg !== 8'hF9) begin bad++; $display("FAIL latency_old: got %h want f9", seg); end
    tick(4);
    total++; if (seg !== 8'hB0) begin bad++; $display("FAIL latency_new: got %h want b0", seg); end
  endtask

  task automatic test_back_to_back;
    data = 20'd111111;
    tick(30);
    data = 20'd222222;
    tick(5);
    data = 20'd333333;
    tick(25);
    total++; if (seg !== 8'hA4) begin bad++; $display("FAIL b2b_first: got %h want a4", seg); end
    tick(21);
    total++; if (seg !== 8'hB0) begin bad++; $display("FAIL b2b_second: got %h want b0", seg); end
  endtask

  task automatic test_seg_en;
    logic [5:0] prev;
    bit found;
    data = 20'd123456; point = 6'd0; sign = 1'b0; seg_en = 1'b1;
    tick(30);
    found = 1'b0;
    prev  = sel;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge sys_clk);
      if (sel == 6'b000100 && prev == 6'b000010) found = 1'b1;
      else prev = sel;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL en_sync: got %0b want 1", found); end
    tick(3);
    seg_en = 1'b0;
    tick(1);
    total++; if (sel !== 6'b0)  begin bad++; $display("FAIL en_off_sel: got %b want 000000", sel); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL en_off_seg: got %h want ff", seg); end
    tick(10);
    total++; if (sel !== 6'b0)  begin bad++; $display("FAIL en_hold_sel: got %b want 000000", sel); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL en_hold_seg: got %h want ff", seg); end
    tick(13);
    seg_en = 1'b1;
    tick(1);
    total++; if (sel !== 6'b010000) begin bad++; $display("FAIL en_resume_sel: got %b want 010000", sel); end
    total++; if (seg !== 8'hA4)     begin bad++; $display("FAIL en_resume_seg: got %h want a4", seg); end
    tick(4);
    total++; if (sel !== 6'b100000) begin bad++; $display("FAIL en_next_sel: got %b want 100000", sel); end
    total++; if (seg !== 8'hF9)     begin bad++; $display("FAIL en_next_seg: got %h want f9", seg); end
  endtask

  task automatic test_reset_midconv;
    data = 20'd654321; point = 6'd0; sign = 1'b0; seg_en = 1'b1;
    tick(5);
    #2 sys_rst_n = 1'b0;
    #1;
    total++; if (sel !== 6'b0)  begin bad++; $display("FAIL rst_async_sel: got %b want 000000", sel); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL rst_async_seg: got %h want ff", seg); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(30);
    exp_seg = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    check_frame_named("rst_midconv");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sign;
    test_point;
    test_zero_sign;
    test_saturate;
    test_latency;
    test_back_to_back;
    test_seg_en;
    test_reset_midconv;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_dyn_disp.md
SEG_DYN_DISP -- requirements
Module: seg_dyn_disp

Interface
REQ-001 CNT_MAX, default 16'd49_999, last value of the scan counter; one digit slot is CNT_MAX+1 clocks (1 ms at 50 MHz).
REQ-002 sys_clk  input  1  system clock; all logic is rising-edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 data  input  20  unsigned binary value to display.
REQ-005 point  input  6  decimal point enables; bit i lights the dp of digit i (digit 0 is rightmost).
REQ-006 sign  input  1  1 = show a minus sign.
REQ-007 seg_en  input  1  1 = display on, 0 = all digits dark.
REQ-008 sel  output  6  one-hot digit select, active-high, bit i = digit i.
REQ-009 seg  output  8  segment pattern, active-low, {dp,g,f,e,d,c,b,a}.

Function
REQ-010 Binary-to-BCD conversion SHALL be sequential shift-add-3: 1 load cycle plus 20 shift cycles.
REQ-011 Inputs SHALL saturate: data > 999_999 is converted as 999_999.
REQ-012 Conversion states SHALL be IDLE -> LOAD -> SHIFT (20 cycles) -> DONE -> IDLE.
REQ-013 IDLE -> LOAD when data differs from the last converted value, or on the first cycle after reset.
REQ-014 A data change during LOAD/SHIFT SHALL be ignored until DONE; IDLE then detects it and restarts.
REQ-015 The display BCD register SHALL update atomically in DONE; latency from stable data is at most 23 cycles.
REQ-016 The scan counter SHALL count 0..CNT_MAX and wrap to 0; at CNT_MAX the digit index SHALL advance 0->1->...->5->0.
REQ-017 sel and seg SHALL be registered; they reflect the current index one cycle after the index changes.
REQ-018 Encoding for digits 0..9 SHALL be C0,F9,A4,B0,99,92,82,F8,80,90; minus is BF; blank is FF.
REQ-019 dp: when point[i]=1, seg[7] SHALL be 0 for digit i; this also un-blanks digit i.
REQ-020 Leading-zero blanking: digit i is shown when i=0, or i <= highest nonzero BCD digit, or i <= highest set point bit.
REQ-021 All other digits SHALL be blanked (FF) while sel still steps through them.
REQ-022 sign=1 SHALL place minus in the digit just left of the highest shown digit; if that digit would be 6, no minus is shown.
REQ-023 seg_en=0 SHALL force sel=6'b0 and seg=8'hFF on the next clock.
REQ-024 The scan counter and conversion SHALL keep running while seg_en=0; scanning resumes at the current index.
REQ-025 point and sign SHALL be sampled each cycle with no conversion latency.

Reset
REQ-026 During reset:
- scan counter = 0, index = 0
- FSM in IDLE, display BCD = 0, last converted value = 0
- sel = 6'b0, seg = 8'hFF
REQ-027 Reset mid-conversion or mid-scan SHALL abandon all state; the first cycle after release starts a new conversion.

Configuration
REQ-028 Macro SEG_LZB_EN defined: blanking and sign display SHALL behave per REQ-020 to REQ-022.
REQ-029 Macro SEG_LZB_EN undefined: all six digits SHALL always be shown, and the sign input SHALL be ignored.

Verification (CNT_MAX=9, SEG_LZB_EN defined unless noted)
REQ-030 data=123456, point=0, sign=0, seg_en=1 -> sel 000001..100000 shows seg 82,92,99,B0,A4,F9, each for 10 clocks.
REQ-031 data=42, sign=1 -> digit0 A4, digit1 99, digit2 BF, digits 3-5 FF.
REQ-032 data=5, point=6'b000100 -> digit0 92, digit1 C0, digit2 40, digits 3-5 FF.
REQ-033 data=20'hFFFFF -> all six digits show 90; data change during SHIFT -> display shows the new value within 46 cycles.
REQ-034 seg_en 1->0 mid-slot -> next clock sel=0, seg=FF; back to 1 -> scanning continues from the current index.
REQ-035 Reset asserted mid-conversion -> sel=0, seg=FF asynchronously; SEG_LZB_EN undefined with data=42, sign=1 -> digits show A4,99,C0,C0,C0,C0.
